// File: rtl/score_keeper.sv
// Game statistics keeper: on each line-clear event, adds base(lines) x (level+1) to a BCD score
// one add per cycle, then updates the BCD line total and the level.
module score_keeper #(
  parameter int unsigned SCORE_DIGITS    = 6,
  parameter int unsigned MAX_LEVEL       = 20,
  parameter int unsigned LINES_PER_LEVEL = 10
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      new_game,
  input  logic                      clean_done,
  input  logic [2:0]                lines,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic [15:0]               lines_bcd,
  output logic [4:0]                level,
  output logic                      busy,
  output logic                      score_update
);

  // Adder spans at least 4 digits so a 1200 base still overflows a narrow score into saturation.
  localparam int unsigned AddDigits = (SCORE_DIGITS > 4) ? SCORE_DIGITS : 4;
  localparam int unsigned AddW      = 4 * AddDigits;
  localparam int unsigned ScoreW    = 4 * SCORE_DIGITS;

  typedef enum logic [1:0] {StIdle, StScore, StLines, StDone} state_e;

  state_e            r_state, w_state_d;
  logic [ScoreW-1:0] r_score, w_score_d, w_score_sum;
  logic [15:0]       r_lines, w_lines_d, w_lines_sum;
  logic [4:0]        r_level, w_level_d;
  logic [4:0]        r_iter, w_iter_d;
  logic [3:0]        r_to_next, w_to_next_d;
  logic [2:0]        r_lines_q, w_lines_q_d;
  logic              r_clean_q, r_busy, r_update;
  logic              w_event;
  logic [2:0]        w_lines_norm;
  logic [15:0]       w_base;
  logic [4:0]        w_to_next_sum;

  assign w_event       = clean_done & ~r_clean_q;
  assign w_lines_norm  = lines[2] ? 3'd4 : lines;
  assign w_to_next_sum = {1'b0, r_to_next} + {2'b00, r_lines_q};

  always_comb begin
    unique case (r_lines_q)
      3'd1:    w_base = 16'h0040;
      3'd2:    w_base = 16'h0100;
      3'd3:    w_base = 16'h0300;
      default: w_base = 16'h1200;
    endcase
  end

  always_comb begin : score_add
    logic [AddW-1:0] a, b, s;
    logic [4:0]      dsum;
    logic            c, ovf;
    a    = '0;
    b    = '0;
    s    = '0;
    dsum = '0;
    c    = 1'b0;
    ovf  = 1'b0;
    a[ScoreW-1:0] = r_score;
    b[15:0]       = w_base;
    for (int i = 0; i < int'(AddDigits); i++) begin
      dsum = {1'b0, a[i*4+:4]} + {1'b0, b[i*4+:4]} + {4'd0, c};
      if (dsum > 5'd9) begin
        dsum = dsum + 5'd6;
        c    = 1'b1;
      end else begin
        c    = 1'b0;
      end
      s[i*4+:4] = dsum[3:0];
      if (i >= int'(SCORE_DIGITS) && dsum[3:0] != 4'd0) ovf = 1'b1;
    end
    ovf         = ovf | c;
    w_score_sum = ovf ? {SCORE_DIGITS{4'h9}} : s[ScoreW-1:0];
  end

  always_comb begin : lines_add
    logic [4:0] dsum;
    logic       c;
    dsum        = '0;
    c           = 1'b0;
    w_lines_sum = '0;
    for (int i = 0; i < 4; i++) begin
      dsum = {1'b0, r_lines[i*4+:4]} + ((i == 0) ? {2'b00, r_lines_q} : 5'd0) + {4'd0, c};
      if (dsum > 5'd9) begin
        dsum = dsum + 5'd6;
        c    = 1'b1;
      end else begin
        c    = 1'b0;
      end
      w_lines_sum[i*4+:4] = dsum[3:0];
    end
    if (c) w_lines_sum = 16'h9999;
  end

  always_comb begin
    w_state_d   = r_state;
    w_score_d   = r_score;
    w_lines_d   = r_lines;
    w_level_d   = r_level;
    w_iter_d    = r_iter;
    w_to_next_d = r_to_next;
    w_lines_q_d = r_lines_q;
    unique case (r_state)
      StIdle: begin
        if (w_event && lines != 3'd0) begin
          w_lines_q_d = w_lines_norm;
          w_iter_d    = r_level;
          w_state_d   = StScore;
        end
      end
      StScore: begin
        w_score_d = w_score_sum;
        if (r_iter == 5'd0) w_state_d = StLines;
        else                w_iter_d  = r_iter - 5'd1;
      end
      StLines: begin
        w_lines_d = w_lines_sum;
        if (w_to_next_sum >= 5'(LINES_PER_LEVEL)) begin
          w_to_next_d = 4'(w_to_next_sum - 5'(LINES_PER_LEVEL));
          if (r_level < 5'(MAX_LEVEL)) w_level_d = r_level + 5'd1;
        end else begin
          w_to_next_d = w_to_next_sum[3:0];
        end
        w_state_d = StDone;
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (new_game) begin
      w_state_d   = StIdle;
      w_score_d   = '0;
      w_lines_d   = '0;
      w_level_d   = '0;
      w_iter_d    = '0;
      w_to_next_d = '0;
      w_lines_q_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_score   <= '0;
      r_lines   <= '0;
      r_level   <= '0;
      r_iter    <= '0;
      r_to_next <= '0;
      r_lines_q <= '0;
      r_clean_q <= 1'b0;
      r_busy    <= 1'b0;
      r_update  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_score   <= w_score_d;
      r_lines   <= w_lines_d;
      r_level   <= w_level_d;
      r_iter    <= w_iter_d;
      r_to_next <= w_to_next_d;
      r_lines_q <= w_lines_q_d;
      r_clean_q <= clean_done;
      r_busy    <= (w_state_d != StIdle);
      r_update  <= (w_state_d == StDone);
    end
  end

  assign score_bcd    = r_score;
  assign lines_bcd    = r_lines;
  assign level        = r_level;
  assign busy         = r_busy;
  assign score_update = r_update;

endmodule
